// File: rtl/usb_packet_assembler.sv
`default_nettype none
// ============================================================================
// Module      : usb_packet_assembler
// Description : Builds USB full-speed packets from a decoded, unstuffed bit
//               stream. Captures the PID and a 64-bit little-endian payload
//               window, checks PID/CRC5/CRC16 and emits a one-cycle DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_packet_assembler #(
    parameter bit DROP_BAD_CRC = 1'b1,
    parameter int MAX_BYTES    = 15
) (
    input  logic        clk,
    input  logic        rst,        // asynchronous, active-low
    input  logic        bit_valid,
    input  logic        bit_in,
    input  logic        sop,
    input  logic        eop,
    input  logic        dir_in,
    output logic [2:0]  usb_state,
    output logic [7:0]  pid,
    output logic [63:0] data,
    output logic [3:0]  byte_cnt,
    output logic        crc_ok,
    output logic        host_dir,
    output logic        pkt_err
);

    localparam logic [2:0]  c_st_idle    = 3'd0;
    localparam logic [2:0]  c_st_pid     = 3'd1;
    localparam logic [2:0]  c_st_payload = 3'd2;
    localparam logic [2:0]  c_st_error   = 3'd3;
    localparam logic [2:0]  c_st_done    = 3'd4;

    localparam logic [4:0]  c_crc5_res   = 5'b01100;
    localparam logic [15:0] c_crc16_res  = 16'h800D;
    localparam logic [3:0]  c_max_bytes  = 4'(MAX_BYTES);

    logic [2:0]  r_state;
    logic [7:0]  r_pid_sh;
    logic [3:0]  r_pid_bits;
    logic [7:0]  r_byte_sh;
    logic [2:0]  r_bit_pos;
    logic [3:0]  r_nbytes;
    logic [63:0] r_data_sh;
    logic [4:0]  r_crc5;
    logic [15:0] r_crc16;
    logic        r_host_dir;
    logic [7:0]  r_pid;
    logic [63:0] r_data;
    logic [3:0]  r_byte_cnt;
    logic        r_crc_ok;
    logic        r_pkt_err;

    logic        w_pid_bit;
    logic [7:0]  w_pid_next;
    logic [3:0]  w_pid_bits_next;
    logic        w_pay_bit;
    logic [7:0]  w_byte_sh_next;
    logic [2:0]  w_bit_pos_next;
    logic        w_byte_done;
    logic [3:0]  w_nbytes_next;
    logic [63:0] w_data_next;
    logic [4:0]  w_crc5_next;
    logic [15:0] w_crc16_next;
    logic [7:0]  w_eval_pid;
    logic        w_pid_ok;
    logic        w_len_ok;
    logic        w_crc_pass;
    logic        w_eop_done;

    // Next-value view of the PID and payload collectors, so that a bit and an
    // eop arriving together are judged on the post-bit counters.
    assign w_pid_bit       = (r_state == c_st_pid) && bit_valid;
    assign w_pid_next      = w_pid_bit ? {bit_in, r_pid_sh[7:1]} : r_pid_sh;
    assign w_pid_bits_next = r_pid_bits + 4'(w_pid_bit);

    assign w_pay_bit      = (r_state == c_st_payload) && bit_valid;
    assign w_byte_sh_next = w_pay_bit ? {bit_in, r_byte_sh[7:1]} : r_byte_sh;
    assign w_bit_pos_next = r_bit_pos + 3'(w_pay_bit);
    assign w_byte_done    = w_pay_bit && (r_bit_pos == 3'd7);
    assign w_nbytes_next  = (w_byte_done && (r_nbytes != c_max_bytes)) ?
                            r_nbytes + 4'd1 : r_nbytes;

    assign w_eval_pid = (r_state == c_st_pid) ? w_pid_next : r_pid_sh;
    assign w_pid_ok   = (w_eval_pid[7:4] == ~w_eval_pid[3:0]);

    // Payload shadow: only the first eight bytes are kept, later bytes still
    // feed the CRC checkers.
    always_comb begin
        w_data_next = r_data_sh;
        if (w_byte_done && (r_nbytes < 4'd8))
            w_data_next[{r_nbytes[2:0], 3'b000} +: 8] = w_byte_sh_next;
    end

    // Serial CRC LFSRs, shifting MSB-ward with the incoming bit as feedback.
    always_comb begin
        w_crc5_next  = r_crc5;
        w_crc16_next = r_crc16;
        if (w_pay_bit) begin
            w_crc5_next  = {r_crc5[3:0], 1'b0} ^
                           ((r_crc5[4] ^ bit_in) ? 5'b00101 : 5'b00000);
            w_crc16_next = {r_crc16[14:0], 1'b0} ^
                           ((r_crc16[15] ^ bit_in) ? 16'h8005 : 16'h0000);
        end
    end

    // End-of-packet verdict by PID class: length rule plus the matching CRC.
    always_comb begin
        w_len_ok   = 1'b1;
        w_crc_pass = 1'b1;
        if (w_eval_pid[1:0] == 2'b01) begin
            w_len_ok   = (w_nbytes_next == 4'd2);
            w_crc_pass = (w_crc5_next == c_crc5_res);
        end else if ((w_eval_pid[3:0] == 4'h3) || (w_eval_pid[3:0] == 4'hB)) begin
            w_len_ok   = (w_nbytes_next >= 4'd2);
            w_crc_pass = (w_crc16_next == c_crc16_res);
        end else if ((w_eval_pid[3:0] == 4'h2) || (w_eval_pid[3:0] == 4'hA) ||
                     (w_eval_pid[3:0] == 4'hE)) begin
            w_len_ok   = (w_nbytes_next == 4'd0);
        end
        w_eop_done = w_pid_ok && (w_bit_pos_next == 3'd0) && w_len_ok &&
                     (w_crc_pass || !DROP_BAD_CRC);
    end

    // Packet FSM; sop from any state restarts collection without DONE/pkt_err.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_st_idle;
            r_pid_sh   <= 8'h00;
            r_pid_bits <= 4'd0;
            r_byte_sh  <= 8'h00;
            r_bit_pos  <= 3'd0;
            r_nbytes   <= 4'd0;
            r_data_sh  <= 64'h0;
            r_crc5     <= 5'h00;
            r_crc16    <= 16'h0000;
            r_host_dir <= 1'b0;
            r_pid      <= 8'h00;
            r_data     <= 64'h0;
            r_byte_cnt <= 4'd0;
            r_crc_ok   <= 1'b0;
            r_pkt_err  <= 1'b0;
        end else begin
            r_pkt_err <= 1'b0;
            if (sop) begin
                r_state    <= c_st_pid;
                r_host_dir <= dir_in;
                r_pid_sh   <= 8'h00;
                r_pid_bits <= 4'd0;
                r_byte_sh  <= 8'h00;
                r_bit_pos  <= 3'd0;
                r_nbytes   <= 4'd0;
                r_data_sh  <= 64'h0;
                r_crc5     <= 5'h1F;
                r_crc16    <= 16'hFFFF;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        r_state <= c_st_idle;
                    end
                    c_st_pid: begin
                        r_pid_sh   <= w_pid_next;
                        r_pid_bits <= w_pid_bits_next;
                        if (eop) begin
                            if ((w_pid_bits_next == 4'd8) && w_eop_done) begin
                                r_state    <= c_st_done;
                                r_pid      <= w_eval_pid;
                                r_data     <= w_data_next;
                                r_byte_cnt <= w_nbytes_next;
                                r_crc_ok   <= w_crc_pass;
                            end else begin
                                r_state   <= c_st_error;
                                r_pkt_err <= 1'b1;
                            end
                        end else if (w_pid_bits_next == 4'd8) begin
                            if (w_pid_ok) begin
                                r_state <= c_st_payload;
                            end else begin
                                r_state   <= c_st_error;
                                r_pkt_err <= 1'b1;
                            end
                        end
                    end
                    c_st_payload: begin
                        r_byte_sh <= w_byte_sh_next;
                        r_bit_pos <= w_bit_pos_next;
                        r_nbytes  <= w_nbytes_next;
                        r_data_sh <= w_data_next;
                        r_crc5    <= w_crc5_next;
                        r_crc16   <= w_crc16_next;
                        if (eop) begin
                            if (w_eop_done) begin
                                r_state    <= c_st_done;
                                r_pid      <= w_eval_pid;
                                r_data     <= w_data_next;
                                r_byte_cnt <= w_nbytes_next;
                                r_crc_ok   <= w_crc_pass;
                            end else begin
                                r_state   <= c_st_error;
                                r_pkt_err <= 1'b1;
                            end
                        end
                    end
                    c_st_error: begin
                        if (eop)
                            r_state <= c_st_idle;
                    end
                    c_st_done: begin
                        r_state <= c_st_idle;
                    end
                    default: begin
                        r_state <= c_st_idle;
                    end
                endcase
            end
        end
    end

    assign usb_state = r_state;
    assign pid       = r_pid;
    assign data      = r_data;
    assign byte_cnt  = r_byte_cnt;
    assign crc_ok    = r_crc_ok;
    assign host_dir  = r_host_dir;
    assign pkt_err   = r_pkt_err;

endmodule
`default_nettype wire

// File: tb/tb_usb_packet_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_packet_assembler
// Description : Directed self-checking bench for usb_packet_assembler. Two
//               instances share stimulus: one drops bad-CRC packets, one
//               completes them with crc_ok low.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_packet_assembler;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic bit_valid = 1'b0;
    logic bit_in = 1'b0;
    logic sop = 1'b0;
    logic eop = 1'b0;
    logic dir_in = 1'b0;

    logic [2:0]  st_a, st_b;
    logic [7:0]  pid_a, pid_b;
    logic [63:0] data_a, data_b;
    logic [3:0]  cnt_a, cnt_b;
    logic        crc_a, crc_b, hd_a, hd_b, err_a, err_b;

    usb_packet_assembler #(.DROP_BAD_CRC(1'b1), .MAX_BYTES(15)) u_dut (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
        .sop(sop), .eop(eop), .dir_in(dir_in), .usb_state(st_a), .pid(pid_a),
        .data(data_a), .byte_cnt(cnt_a), .crc_ok(crc_a), .host_dir(hd_a),
        .pkt_err(err_a)
    );

    usb_packet_assembler #(.DROP_BAD_CRC(1'b0), .MAX_BYTES(15)) u_dut_keep (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
        .sop(sop), .eop(eop), .dir_in(dir_in), .usb_state(st_b), .pid(pid_b),
        .data(data_b), .byte_cnt(cnt_b), .crc_ok(crc_b), .host_dir(hd_b),
        .pkt_err(err_b)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done_a = 0, n_err_a = 0, n_done_b = 0, n_err_b = 0;
    int d_a, e_a, d_b, e_b;

    bit         bq[$];
    logic [7:0] pay[$];

    // DONE cycles and pkt_err pulses observed on the falling edge
    always @(negedge clk) begin
        if (st_a == 3'd4) n_done_a++;
        if (err_a)        n_err_a++;
        if (st_b == 3'd4) n_done_b++;
        if (err_b)        n_err_b++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) bq.push_back(b[i]);
    endtask

    task automatic push_pay(input logic [7:0] b);
        pay.push_back(b);
        push_byte(b);
    endtask

    // Appends the complemented CRC16 of the payload, MSB first; flip corrupts
    // the first transmitted CRC byte.
    task automatic push_crc16(input bit flip);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (pay[k]) begin
            for (int i = 0; i < 8; i++) begin
                fb = c[15] ^ pay[k][i];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
        end
        for (int i = 15; i >= 0; i--) bq.push_back(~c[i] ^ (flip && (i >= 8)));
    endtask

    task automatic start_pkt(input logic d);
        bq.delete();
        pay.delete();
        sop = 1'b1;
        dir_in = d;
        tick();
        sop = 1'b0;
    endtask

    task automatic send_bits();
        foreach (bq[i]) begin
            bit_valid = 1'b1;
            bit_in = bq[i];
            tick();
        end
        bit_valid = 1'b0;
        bit_in = 1'b0;
    endtask

    task automatic send_eop();
        eop = 1'b1;
        tick();
        eop = 1'b0;
    endtask

    task automatic snap();
        d_a = n_done_a; e_a = n_err_a; d_b = n_done_b; e_b = n_err_b;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_state", 64'(st_a), 64'd0);
        check("rst_pid", 64'(pid_a), 64'h0);
        check("rst_data", data_a, 64'h0);
        check("rst_cnt", 64'(cnt_a), 64'd0);
        check("rst_crc", 64'(crc_a), 64'd0);
        check("rst_dir", 64'(hd_a), 64'd0);
        check("rst_err", 64'(err_a), 64'd0);
        rst = 1'b1;
        tick();

        // OUT token addr 0 endp 0: E1 00 10
        snap();
        start_pkt(1'b1);
        push_byte(8'hE1); push_byte(8'h00); push_byte(8'h10);
        send_bits();
        send_eop();
        check("out_state", 64'(st_a), 64'd4);
        check("out_pid", 64'(pid_a), 64'hE1);
        check("out_data", data_a, 64'h1000);
        check("out_addr_endp", 64'(data_a[10:7]), 64'h0);
        check("out_cnt", 64'(cnt_a), 64'd2);
        check("out_crc", 64'(crc_a), 64'd1);
        check("out_dir", 64'(hd_a), 64'd1);
        tick();
        check("out_idle", 64'(st_a), 64'd0);
        check("out_done_cnt", 64'(n_done_a - d_a), 64'd1);

        // DATA1 keyboard report
        start_pkt(1'b0);
        push_byte(8'h4B);
        push_pay(8'h02); push_pay(8'h00); push_pay(8'h39); push_pay(8'h00);
        push_pay(8'h00); push_pay(8'h00); push_pay(8'h00); push_pay(8'h00);
        push_crc16(1'b0);
        send_bits();
        send_eop();
        check("kbd_state", 64'(st_a), 64'd4);
        check("kbd_pid", 64'(pid_a), 64'h4B);
        check("kbd_data", data_a, 64'h0000_0000_0039_0002);
        check("kbd_cnt", 64'(cnt_a), 64'd10);
        check("kbd_crc", 64'(crc_a), 64'd1);
        check("kbd_dir", 64'(hd_a), 64'd0);
        tick();

        // Bad PID E2
        snap();
        start_pkt(1'b1);
        push_byte(8'hE2);
        send_bits();
        check("badpid_state", 64'(st_a), 64'd3);
        check("badpid_err", 64'(err_a), 64'd1);
        tick();
        check("badpid_err_pulse", 64'(err_a), 64'd0);
        send_eop();
        check("badpid_idle", 64'(st_a), 64'd0);
        check("badpid_keep_pid", 64'(pid_a), 64'h4B);
        check("badpid_keep_data", data_a, 64'h0000_0000_0039_0002);
        check("badpid_no_done", 64'(n_done_a - d_a), 64'd0);
        check("badpid_err_cnt", 64'(n_err_a - e_a), 64'd1);

        // Zero-length DATA0: C3 00 00
        start_pkt(1'b0);
        push_byte(8'hC3); push_byte(8'h00); push_byte(8'h00);
        send_bits();
        send_eop();
        check("zlp_state", 64'(st_a), 64'd4);
        check("zlp_cnt", 64'(cnt_a), 64'd2);
        check("zlp_crc", 64'(crc_a), 64'd1);
        check("zlp_data", data_a, 64'h0);
        tick();

        // DATA0 with a corrupted CRC byte
        snap();
        start_pkt(1'b0);
        push_byte(8'hC3);
        push_pay(8'h01); push_pay(8'h02); push_pay(8'h03);
        push_crc16(1'b1);
        send_bits();
        send_eop();
        check("badcrc_drop_state", 64'(st_a), 64'd3);
        check("badcrc_keep_state", 64'(st_b), 64'd4);
        check("badcrc_keep_crc", 64'(crc_b), 64'd0);
        check("badcrc_keep_cnt", 64'(cnt_b), 64'd5);
        check("badcrc_keep_pid", 64'(pid_b), 64'hC3);
        tick(); tick();
        check("badcrc_drop_no_done", 64'(n_done_a - d_a), 64'd0);
        check("badcrc_drop_err", 64'(n_err_a - e_a), 64'd1);
        check("badcrc_drop_cnt", 64'(cnt_a), 64'd2);
        check("badcrc_keep_done", 64'(n_done_b - d_b), 64'd1);
        check("badcrc_keep_no_err", 64'(n_err_b - e_b), 64'd0);
        send_eop();
        check("badcrc_drop_idle", 64'(st_a), 64'd0);

        // Truncated DATA0: 12 payload bits
        snap();
        start_pkt(1'b1);
        push_byte(8'hC3); push_byte(8'hAA);
        bq.push_back(1'b1); bq.push_back(1'b0); bq.push_back(1'b1); bq.push_back(1'b0);
        send_bits();
        send_eop();
        check("trunc_state", 64'(st_a), 64'd3);
        check("trunc_err", 64'(err_a), 64'd1);
        send_eop();
        check("trunc_idle", 64'(st_a), 64'd0);
        tick();
        check("trunc_no_done", 64'(n_done_a - d_a), 64'd0);
        check("trunc_err_cnt", 64'(n_err_a - e_a), 64'd1);

        // Reset in the middle of payload byte 3
        snap();
        start_pkt(1'b1);
        push_byte(8'hC3); push_pay(8'h11); push_pay(8'h22);
        bq.push_back(1'b1); bq.push_back(1'b1); bq.push_back(1'b0);
        send_bits();
        #2 rst = 1'b0;
        #1;
        check("midrst_state", 64'(st_a), 64'd0);
        check("midrst_pid", 64'(pid_a), 64'h0);
        check("midrst_dir", 64'(hd_a), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        check("midrst_no_done", 64'(n_done_a - d_a), 64'd0);

        // ACK with eop on the 8th PID bit
        start_pkt(1'b0);
        push_byte(8'hD2);
        for (int i = 0; i < 7; i++) begin
            bit_valid = 1'b1; bit_in = bq[i]; tick();
        end
        bit_valid = 1'b1; bit_in = bq[7]; eop = 1'b1;
        tick();
        bit_valid = 1'b0; bit_in = 1'b0; eop = 1'b0;
        check("ack_state", 64'(st_a), 64'd4);
        check("ack_pid", 64'(pid_a), 64'hD2);
        check("ack_cnt", 64'(cnt_a), 64'd0);
        check("ack_crc", 64'(crc_a), 64'd1);
        check("ack_data", data_a, 64'h0);
        tick();

        // sop mid-payload aborts, then a SETUP completes
        snap();
        start_pkt(1'b0);
        push_byte(8'h4B); push_pay(8'h55);
        send_bits();
        start_pkt(1'b1);
        push_byte(8'h2D); push_byte(8'h00); push_byte(8'h10);
        send_bits();
        send_eop();
        check("abort_state", 64'(st_a), 64'd4);
        check("abort_pid", 64'(pid_a), 64'h2D);
        check("abort_dir", 64'(hd_a), 64'd1);
        tick();
        check("abort_done_cnt", 64'(n_done_a - d_a), 64'd1);
        check("abort_no_err", 64'(n_err_a - e_a), 64'd0);

        // Long DATA0: 14 payload + 2 CRC bytes, byte count saturates
        start_pkt(1'b0);
        push_byte(8'hC3);
        for (int i = 0; i < 14; i++) push_pay(8'h10 + 8'(i));
        push_crc16(1'b0);
        send_bits();
        send_eop();
        check("sat_state", 64'(st_a), 64'd4);
        check("sat_cnt", 64'(cnt_a), 64'd15);
        check("sat_data", data_a, 64'h1716_1514_1312_1110);
        check("sat_crc", 64'(crc_a), 64'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
